// File: rtl/sram_rr_port.sv
// Simulation SRAM behind a valid/ready request/response port. Requests are registered,
// read data travels a fixed-latency pipeline, and a credit-guarded queue absorbs stalls.
module sram_rr_port #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int WMASK_WIDTH  = 4,
    parameter int READ_LATENCY = 2,
    parameter int WRITE_ACK    = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATA_WIDTH-1:0]  resp_rdata,
    output logic                   busy
);

    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
    localparam int LW         = DATA_WIDTH / WMASK_WIDTH;
    localparam int RESP_DEPTH = READ_LATENCY + 1;
    localparam int CW         = $clog2(RESP_DEPTH + 1);
    localparam int PW         = $clog2(RESP_DEPTH);
    localparam logic [CW-1:0] CREDITS_FULL = CW'(RESP_DEPTH);

    // Handshake: a request transfers on a cycle where req_valid && req_ready, a response
    // transfers where resp_valid && resp_ready; neither ready depends on the other side's valid.

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic [CW-1:0]          credits;
    logic                   accept;
    logic                   take;
    logic                   pop;

    logic                   r_valid;
    logic                   r_resp;
    logic                   r_we;
    logic [WMASK_WIDTH-1:0] r_wmask;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [DATA_WIDTH-1:0]  rd_word;

    logic                   arrive_valid;
    logic [DATA_WIDTH-1:0]  arrive_data;

    logic [DATA_WIDTH-1:0]  q_mem [RESP_DEPTH];
    logic [PW-1:0]          q_wr;
    logic [PW-1:0]          q_rd;
    logic [CW-1:0]          q_count;
    logic                   q_empty;
    logic                   q_push;
    logic                   q_pop;
    logic [DATA_WIDTH-1:0]  head_data;

    // Credits are registered so req_ready never sees resp_ready combinationally.
    assign req_ready = !reset && (credits != '0);
    assign accept    = req_valid && req_ready;
    assign take      = accept && (!req_we || (WRITE_ACK != 0));

    always_ff @(posedge clock) begin
        if (reset) begin
            credits <= CREDITS_FULL;
        end else begin
            credits <= credits - CW'(take) + CW'(pop);
        end
    end

    assign busy = !reset && (credits != CREDITS_FULL);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_resp  <= 1'b0;
        end else begin
            r_valid <= accept;
            r_resp  <= take;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            r_we    <= req_we;
            r_wmask <= req_wmask;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && r_valid && r_we) begin
            for (int i = 0; i < WMASK_WIDTH; i++) begin
                if (r_wmask[i]) begin
                    mem[r_addr][i*LW +: LW] <= r_wdata[i*LW +: LW];
                end
            end
        end
    end

    // Write acks carry zero data.
    assign rd_word = r_we ? '0 : mem[r_addr];

    // The registered request already costs one cycle; the rest is a shift pipeline.
    if (READ_LATENCY == 1) begin : g_no_pipe
        assign arrive_valid = r_resp;
        assign arrive_data  = rd_word;
    end else begin : g_pipe
        localparam int NS = READ_LATENCY - 1;
        logic                  pv [NS];
        logic [DATA_WIDTH-1:0] pd [NS];

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int k = 0; k < NS; k++) pv[k] <= 1'b0;
            end else begin
                pv[0] <= r_resp;
                for (int k = 1; k < NS; k++) pv[k] <= pv[k-1];
            end
        end

        always_ff @(posedge clock) begin
            pd[0] <= rd_word;
            for (int k = 1; k < NS; k++) pd[k] <= pd[k-1];
        end

        assign arrive_valid = pv[NS-1];
        assign arrive_data  = pd[NS-1];
    end

    // An arriving response bypasses the queue only when the queue is empty and it pops at once.
    assign q_empty   = (q_count == '0);
    assign head_data = q_empty ? arrive_data : q_mem[q_rd];
    assign resp_valid = !reset && (!q_empty || arrive_valid);
    assign resp_rdata = resp_valid ? head_data : '0;
    assign pop        = resp_valid && resp_ready;
    assign q_push     = arrive_valid && !(q_empty && resp_ready);
    assign q_pop      = pop && !q_empty;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            q_wr    <= '0;
            q_rd    <= '0;
            q_count <= '0;
        end else begin
            if (q_push) q_wr <= ptr_inc(q_wr);
            if (q_pop)  q_rd <= ptr_inc(q_rd);
            q_count <= q_count + CW'(q_push) - CW'(q_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (q_push) begin
            q_mem[q_wr] <= arrive_data;
        end
    end

endmodule
